// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//   Front end for the piano mode FSM and the play-mode blocks. Synchronises and
//   debounces the piano key switches plus the mode push-button. It produces:
//   - clean key levels
//   - one-cycle press/release pulses
//   - a registered lowest-index note
//   - a one-cycle mode-advance strobe
//   Optional feature macro: MODE_LONGPRESS_EN. When it is defined, a long hold of the
//   mode button raises menu_req instead of mode_pulse.
module key_input_conditioner #(
  parameter int NUM_KEYS         = 8,
  parameter int DEBOUNCE_CYCLES  = 200000,
  parameter int LONGPRESS_CYCLES = 100000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                mode_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [2:0]          note_idx,
  output logic                note_valid,
  output logic                mode_pulse,
  output logic                menu_req
);

  // Channel NUM_KEYS is the mode button; channels below it are the keys.
  localparam int CH      = NUM_KEYS + 1;
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > LONGPRESS_CYCLES) ? DEBOUNCE_CYCLES
                                                                : LONGPRESS_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CH-1:0] raw_all;
  logic [CH-1:0] sync_q1, sync_q2;
  logic [CH-1:0] stable_q;
  logic [CH-1:0] rise_q, fall_q;
  logic [CH-1:0] toggle;
  logic [CW-1:0] db_cnt [CH];
  logic [2:0]    enc_idx;
  logic          mode_stable;
  logic          mode_falling;

  assign raw_all = {mode_raw, key_raw};

  // Two-flop synchroniser for every asynchronous input channel.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_all;
      sync_q2 <= sync_q1;
    end
  end

  // A channel accepts its new level on the edge that completes the required stable run.
  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    toggle = '0;
    for (int c = 0; c < CH; c++) begin
      toggle[c] = (sync_q2[c] != stable_q[c]) && (db_cnt[c] == DB_LAST);
    end
  end

  // Per-channel debounce counters, stable levels and the edge pulses they generate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      // NOTE: counters are flops, not RAM, so they are reset; a partial count must never survive reset.
      for (int c = 0; c < CH; c++) begin
        db_cnt[c] <= '0;
      end
    end else begin
      rise_q <= toggle & sync_q2;
      fall_q <= toggle & ~sync_q2;
      for (int c = 0; c < CH; c++) begin
        if (sync_q2[c] == stable_q[c]) begin
          db_cnt[c] <= '0;
        end else if (toggle[c]) begin
          stable_q[c] <= sync_q2[c];
          db_cnt[c]   <= '0;
        end else if (db_cnt[c] != '1) begin
          db_cnt[c] <= db_cnt[c] + 1'b1;
        end
      end
    end
  end

  assign key_state    = stable_q[NUM_KEYS-1:0];
  assign key_press    = rise_q[NUM_KEYS-1:0];
  assign key_release  = fall_q[NUM_KEYS-1:0];
  assign mode_stable  = stable_q[NUM_KEYS];
  assign mode_falling = toggle[NUM_KEYS] & stable_q[NUM_KEYS];

  // Lowest-numbered pressed key wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    enc_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_state[i]) enc_idx = 3'(i);
    end
  end

  // Registered note output; the index holds while no key is down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_idx   <= '0;
      note_valid <= 1'b0;
    end else if (|key_state) begin
      note_idx   <= enc_idx;
      note_valid <= 1'b1;
    end else begin
      note_valid <= 1'b0;
    end
  end

`ifdef MODE_LONGPRESS_EN
  localparam logic [CW-1:0] LP_LAST = CW'(LONGPRESS_CYCLES - 1);

  logic [CW-1:0] hold_cnt;
  logic          consumed_q;
  logic          mode_pulse_q;
  logic          menu_req_q;
  logic          unused_mode_edges;

  assign unused_mode_edges = ^{rise_q[NUM_KEYS], fall_q[NUM_KEYS]};

  // Hold timer: a long hold raises menu_req once and swallows the release strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt     <= '0;
      consumed_q   <= 1'b0;
      mode_pulse_q <= 1'b0;
      menu_req_q   <= 1'b0;
    end else begin
      mode_pulse_q <= 1'b0;
      menu_req_q   <= 1'b0;
      if (mode_falling) begin
        mode_pulse_q <= ~consumed_q;
        hold_cnt     <= '0;
        consumed_q   <= 1'b0;
      end else if (mode_stable) begin
        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
        if (!consumed_q && hold_cnt == LP_LAST) begin
          menu_req_q <= 1'b1;
          consumed_q <= 1'b1;
        end
      end
    end
  end

  assign mode_pulse = mode_pulse_q;
  assign menu_req   = menu_req_q;
`else
  logic unused_mode_edges;

  assign unused_mode_edges = ^{fall_q[NUM_KEYS], mode_stable, mode_falling};
  assign mode_pulse        = rise_q[NUM_KEYS];
  assign menu_req          = 1'b0;
`endif

endmodule
